// File: rtl/denormalize.sv
// rtl/denormalize.sv - arithmetic right-shift denormalizer for a signed sample pair
// Optional round-half-up stage compiled in with DENORMALIZE_ROUND_EN.
module denormalize #(
   parameter int PAR_DATA_WIDTH  = 16,
   parameter int PAR_SHIFT_WIDTH = 5
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_vld,
   input  logic [PAR_DATA_WIDTH-1:0]  i_dat_1,
   input  logic [PAR_DATA_WIDTH-1:0]  i_dat_2,
   input  logic [PAR_SHIFT_WIDTH-1:0] i_shift,
   output logic                       o_rdy,
   output logic                       o_vld,
   output logic [PAR_DATA_WIDTH-1:0]  o_dat_1,
   output logic [PAR_DATA_WIDTH-1:0]  o_dat_2
);

   localparam int          CNT_W = (PAR_DATA_WIDTH > 2) ? $clog2(PAR_DATA_WIDTH) : 1;
   localparam logic [31:0] MAX_S = 32'(PAR_DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ROUND = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   state_t                    state_q;
   logic                      rdy_q;
   logic                      vld_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [PAR_DATA_WIDTH-1:0] dat_1_q;
   logic [PAR_DATA_WIDTH-1:0] dat_2_q;
   logic [PAR_DATA_WIDTH-1:0] out_1_q;
   logic [PAR_DATA_WIDTH-1:0] out_2_q;
   logic [CNT_W-1:0]          shift_d;
`ifdef DENORMALIZE_ROUND_EN
   logic                      rb_1_q;
   logic                      rb_2_q;
`endif

   // Shifting further than W-1 gives the same result as W-1 (all sign bits).
   always_comb begin
      shift_d = CNT_W'(i_shift);
      if (32'(i_shift) > MAX_S) begin
         shift_d = CNT_W'(MAX_S);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         dat_1_q <= '0;
         dat_2_q <= '0;
         out_1_q <= '0;
         out_2_q <= '0;
`ifdef DENORMALIZE_ROUND_EN
         rb_1_q  <= 1'b0;
         rb_2_q  <= 1'b0;
`endif
      end else begin
         vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (i_vld && rdy_q) begin
                  rdy_q   <= 1'b0;
                  dat_1_q <= i_dat_1;
                  dat_2_q <= i_dat_2;
                  cnt_q   <= shift_d;
`ifdef DENORMALIZE_ROUND_EN
                  rb_1_q  <= 1'b0;
                  rb_2_q  <= 1'b0;
`endif
                  state_q <= (shift_d == '0) ? ST_OUT : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               dat_1_q <= {dat_1_q[PAR_DATA_WIDTH-1], dat_1_q[PAR_DATA_WIDTH-1:1]};
               dat_2_q <= {dat_2_q[PAR_DATA_WIDTH-1], dat_2_q[PAR_DATA_WIDTH-1:1]};
`ifdef DENORMALIZE_ROUND_EN
               rb_1_q  <= dat_1_q[0];
               rb_2_q  <= dat_2_q[0];
`endif
               cnt_q   <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
`ifdef DENORMALIZE_ROUND_EN
                  state_q <= ST_ROUND;
`else
                  state_q <= ST_OUT;
`endif
               end
            end
`ifdef DENORMALIZE_ROUND_EN
            // At least one shift happened, so adding the round bit cannot overflow.
            ST_ROUND: begin
               dat_1_q <= dat_1_q + {{(PAR_DATA_WIDTH-1){1'b0}}, rb_1_q};
               dat_2_q <= dat_2_q + {{(PAR_DATA_WIDTH-1){1'b0}}, rb_2_q};
               state_q <= ST_OUT;
            end
`endif
            ST_OUT: begin
               vld_q   <= 1'b1;
               out_1_q <= dat_1_q;
               out_2_q <= dat_2_q;
               state_q <= ST_IDLE;
            end
            default: begin
               rdy_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rdy   = rdy_q;
   assign o_vld   = vld_q;
   assign o_dat_1 = out_1_q;
   assign o_dat_2 = out_2_q;

endmodule

// File: tb/tb_denormalize.sv
// tb/tb_denormalize.sv - scoreboard bench for denormalize (both DENORMALIZE_ROUND_EN builds)
module tb_denormalize;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_vld;
   logic [15:0] i_dat_1;
   logic [15:0] i_dat_2;
   logic [4:0]  i_shift;
   logic        o_rdy;
   logic        o_vld;
   logic [15:0] o_dat_1;
   logic [15:0] o_dat_2;

   denormalize #(.PAR_DATA_WIDTH(16), .PAR_SHIFT_WIDTH(5)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_vld   (i_vld),
      .i_dat_1 (i_dat_1),
      .i_dat_2 (i_dat_2),
      .i_shift (i_shift),
      .o_rdy   (o_rdy),
      .o_vld   (o_vld),
      .o_dat_1 (o_dat_1),
      .o_dat_2 (o_dat_2)
   );

   typedef struct {
      logic [15:0] e1;
      logic [15:0] e2;
      int          ecyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] last_out = 32'h0;
   int          last_acc = -1;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int lat(input int s);
      int se;
      se = (s > 15) ? 15 : s;
`ifdef DENORMALIZE_ROUND_EN
      return (se == 0) ? 1 : se + 2;
`else
      return se + 1;
`endif
   endfunction

   // Reference by integer floor division, independent of any shifting.
   function automatic logic [15:0] model(input logic [15:0] x, input int s);
      int v, d, q, se;
      se = (s > 15) ? 15 : s;
      v  = $signed(x);
      d  = 1 << se;
`ifdef DENORMALIZE_ROUND_EN
      v  = 2 * v + d;
      d  = 2 * d;
`endif
      q  = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      return 16'(q);
   endfunction

   // Called at a negedge; returns at a negedge one cycle after the accept.
   task automatic send(input logic [15:0] d1, input logic [15:0] d2, input int sh,
                       input logic [15:0] e1, input logic [15:0] e2, input bit push);
      int waited = 0;
      while (!o_rdy && waited < 100) begin
         @(negedge i_clk);
         waited++;
      end
      if (!o_rdy) begin
         chk("rdy_timeout", 32'd0, 32'd1);
      end else begin
         i_vld   = 1'b1;
         i_dat_1 = d1;
         i_dat_2 = d2;
         i_shift = 5'(sh);
         if (push) sb_q.push_back('{e1, e2, cyc + 1 + lat(sh)});
         @(negedge i_clk);
         i_vld   = 1'b0;
         i_dat_1 = 16'hDEAD;
         i_dat_2 = 16'hBEEF;
         i_shift = 5'd2;
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         last_out = 32'h0;
      end else if (o_vld) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_vld", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("dat_1", {16'h0, o_dat_1}, {16'h0, e.e1});
            chk("dat_2", {16'h0, o_dat_2}, {16'h0, e.e2});
            chk("latency", cyc, e.ecyc);
         end
         last_out = {o_dat_1, o_dat_2};
      end else begin
         chk("dat_hold", {o_dat_1, o_dat_2}, last_out);
      end
   end

   initial begin
      int waited;
      i_rst_n = 1'b0;
      i_vld   = 1'b0;
      i_dat_1 = 16'h0;
      i_dat_2 = 16'h0;
      i_shift = 5'd0;
      repeat (3) @(negedge i_clk);
      chk("reset_rdy", {31'h0, o_rdy}, 32'd0);
      chk("reset_vld", {31'h0, o_vld}, 32'd0);
      chk("reset_dat", {o_dat_1, o_dat_2}, 32'h0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rdy_after_reset", {31'h0, o_rdy}, 32'd1);

`ifdef DENORMALIZE_ROUND_EN
      send(16'h4000, 16'hC000, 3,  16'h0800, 16'hF800, 1'b1);
      send(16'h0005, 16'hFFFB, 1,  16'h0003, 16'hFFFE, 1'b1);
      send(16'h1234, 16'h8001, 0,  16'h1234, 16'h8001, 1'b1);
      send(16'h8000, 16'h7FFF, 31, 16'hFFFF, 16'h0001, 1'b1);
      send(16'hFFFF, 16'h0007, 4,  16'h0000, 16'h0000, 1'b1);
      send(16'h7FFF, 16'h8000, 15, 16'h0001, 16'hFFFF, 1'b1);
      send(16'h000C, 16'hFFF4, 3,  16'h0002, 16'hFFFF, 1'b1);
      send(16'h0100, 16'hFF00, 16, 16'h0000, 16'h0000, 1'b1);
`else
      send(16'h4000, 16'hC000, 3,  16'h0800, 16'hF800, 1'b1);
      send(16'h0005, 16'hFFFB, 1,  16'h0002, 16'hFFFD, 1'b1);
      send(16'h1234, 16'h8001, 0,  16'h1234, 16'h8001, 1'b1);
      send(16'h8000, 16'h7FFF, 31, 16'hFFFF, 16'h0000, 1'b1);
      send(16'hFFFF, 16'h0007, 4,  16'hFFFF, 16'h0000, 1'b1);
      send(16'h7FFF, 16'h8000, 15, 16'h0000, 16'hFFFF, 1'b1);
      send(16'h000C, 16'hFFF4, 3,  16'h0001, 16'hFFFE, 1'b1);
      send(16'h0100, 16'hFF00, 16, 16'h0000, 16'hFFFF, 1'b1);
`endif

      // i_vld held high with fresh data every cycle; accepts must be L+2 apart.
      waited = 0;
      while (!o_rdy && waited < 100) begin
         @(negedge i_clk);
         waited++;
      end
      last_acc = -1;
      i_shift  = 5'd1;
      i_vld    = 1'b1;
      for (int k = 0; k < 30; k++) begin
         i_dat_1 = 16'h0011 + 16'(k);
         i_dat_2 = 16'hFF80 - 16'(3 * k);
         if (o_rdy) begin
            sb_q.push_back('{model(i_dat_1, 1), model(i_dat_2, 1), cyc + 1 + lat(1)});
            if (last_acc >= 0) chk("stream_gap", cyc - last_acc, lat(1) + 2);
            last_acc = cyc;
         end
         @(negedge i_clk);
      end
      i_vld = 1'b0;

      // Reset in the middle of a long shift: nothing may come out.
      send(16'h4000, 16'h2000, 10, 16'h0, 16'h0, 1'b0);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("midrst_rdy", {31'h0, o_rdy}, 32'd0);
      chk("midrst_vld", {31'h0, o_vld}, 32'd0);
      @(negedge i_clk);
      chk("midrst_rdy2", {31'h0, o_rdy}, 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("midrst_rdy_release", {31'h0, o_rdy}, 32'd1);
      repeat (15) @(negedge i_clk);
      chk("midrst_no_output", 32'(sb_q.size()), 32'd0);
      send(16'h000C, 16'hFFF4, 3, model(16'h000C, 3), model(16'hFFF4, 3), 1'b1);

      waited = 0;
      while (sb_q.size() != 0 && waited < 200) begin
         @(negedge i_clk);
         waited++;
      end
      chk("queue_drain", 32'(sb_q.size()), 32'd0);
      repeat (5) @(negedge i_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
